// File: rtl/rtc_field_editor_pkg.sv
// Shared state encoding and RTC field table for the field editor.
// The RTC_BCD_EN macro selects packed-BCD encoding of the table limits.
package rtc_field_editor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_EDIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] min_v;
    logic [7:0] max_v;
  } field_t;

  function automatic logic [7:0] enc(input int v);
`ifdef RTC_BCD_EN
    return 8'(((v / 10) << 4) | (v % 10));
`else
    return 8'(v);
`endif
  endfunction

  // Entries past the ninth exist only for wider builds; they behave like a 0..99 counter.
  function automatic field_t field_entry(input logic [3:0] idx);
    field_t f;
    case (idx)
      4'd0:    f = '{addr: 8'h00, min_v: enc(0), max_v: enc(1)};
      4'd1:    f = '{addr: 8'h21, min_v: enc(0), max_v: enc(59)};
      4'd2:    f = '{addr: 8'h22, min_v: enc(0), max_v: enc(59)};
      4'd3:    f = '{addr: 8'h23, min_v: enc(0), max_v: enc(23)};
      4'd4:    f = '{addr: 8'h24, min_v: enc(1), max_v: enc(31)};
      4'd5:    f = '{addr: 8'h25, min_v: enc(1), max_v: enc(12)};
      4'd6:    f = '{addr: 8'h26, min_v: enc(0), max_v: enc(99)};
      4'd7:    f = '{addr: 8'h27, min_v: enc(1), max_v: enc(7)};
      4'd8:    f = '{addr: 8'h28, min_v: enc(1), max_v: enc(53)};
      default: f = '{addr: 8'h20 + 8'(idx), min_v: enc(0), max_v: enc(99)};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rtc_field_editor_if.sv
// RTC register bus between the field editor (master) and the RTC bus controller (slave).
interface rtc_field_editor_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;
  logic              wr_ack;

  modport master (output wr_req, address, wr_data, input rd_data, wr_ack);
  modport slave  (input wr_req, address, wr_data, output rd_data, wr_ack);
endinterface

// File: rtl/rtc_field_step.sv
// Combinational wrap-around increment/decrement within [min_v, max_v].
// RTC_BCD_EN selects per-digit packed-BCD stepping instead of binary.
module rtc_field_step
  import rtc_field_editor_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] value,
  input  logic [DATA_W-1:0] min_v,
  input  logic [DATA_W-1:0] max_v,
  input  logic              up,
  output logic [DATA_W-1:0] next_v
);

`ifdef RTC_BCD_EN
  localparam int N_DIG = DATA_W / 4;

  logic       carry;
  logic [3:0] dig;

  always_comb begin
    next_v = value;
    carry  = 1'b1;
    dig    = '0;
    if (up ? (value >= max_v) : (value <= min_v)) begin
      next_v = up ? min_v : max_v;
    end else begin
      // Ripple a carry (or borrow) upward through the decimal digits.
      for (int d = 0; d < N_DIG; d++) begin
        dig = value[d*4 +: 4];
        if (carry) begin
          if (up) begin
            if (dig >= 4'd9) dig = 4'd0;
            else begin
              dig   = dig + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (dig == 4'd0) dig = 4'd9;
            else begin
              dig   = dig - 4'd1;
              carry = 1'b0;
            end
          end
        end
        next_v[d*4 +: 4] = dig;
      end
    end
  end
`else
  always_comb begin
    next_v = value;
    if (up) next_v = (value >= max_v) ? min_v : value + DATA_W'(1);
    else    next_v = (value <= min_v) ? max_v : value - DATA_W'(1);
  end
`endif

endmodule

// File: rtl/rtc_field_editor.sv
// Button-driven RTC field editor: selects a field, loads it, steps it and writes it back.
// Define RTC_BCD_EN for packed-BCD field values.
//
// state    | meaning
// ST_IDLE  | edit mode off, campo retained
// ST_LOAD  | one cycle: capture rd_data of the selected field
// ST_EDIT  | waiting for a single button edge
// ST_WRITE | wr_req held until wr_ack
module rtc_field_editor
  import rtc_field_editor_pkg::*;
#(
  parameter int N_FIELDS = 9,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     escribe,
  input  logic                     crono,
  input  logic                     suma,
  input  logic                     resta,
  input  logic                     izquierda,
  input  logic                     derecha,
  rtc_field_editor_if.master       bus,
  output logic [3:0]               campo,
  output logic                     busy
);

  localparam logic [3:0] LAST_FIELD = 4'(N_FIELDS - 1);

  state_t            state;
  logic [DATA_W-1:0] value;
  logic [3:0]        btn_prev;
  logic              crono_pend;
  logic [3:0]        btn_now;
  logic [3:0]        btn_edge;
  logic              one_edge;
  field_t            fld;
  logic [DATA_W-1:0] fmin;
  logic [DATA_W-1:0] fmax;
  logic [DATA_W-1:0] step_val;

  // Bit order {derecha, izquierda, resta, suma}.
  assign btn_now  = {derecha, izquierda, resta, suma};
  assign btn_edge = btn_now & ~btn_prev;
  assign one_edge = (btn_edge != 4'b0) && ((btn_edge & (btn_edge - 4'd1)) == 4'b0);

  assign fld  = field_entry(campo);
  assign fmin = DATA_W'(fld.min_v);
  assign fmax = DATA_W'(fld.max_v);

  assign bus.address = ADDR_W'(fld.addr);
  assign bus.wr_data = value;

  rtc_field_step #(.DATA_W(DATA_W)) u_step (
    .value  (value),
    .min_v  (fmin),
    .max_v  (fmax),
    .up     (btn_edge[0]),
    .next_v (step_val)
  );

  function automatic logic value_ok(input logic [DATA_W-1:0] v,
                                    input logic [DATA_W-1:0] lo,
                                    input logic [DATA_W-1:0] hi);
    logic ok;
    ok = (v >= lo) && (v <= hi);
`ifdef RTC_BCD_EN
    for (int d = 0; d < DATA_W / 4; d++)
      if (v[d*4 +: 4] > 4'd9) ok = 1'b0;
`endif
    return ok;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      campo      <= '0;
      value      <= '0;
      bus.wr_req <= 1'b0;
      busy       <= 1'b0;
      btn_prev   <= '0;
      crono_pend <= 1'b0;
    end else begin
      btn_prev <= btn_now;
      case (state)
        ST_IDLE: begin
          if (crono) campo <= '0;
          if (escribe) begin
            state <= ST_LOAD;
            busy  <= 1'b1;
          end
        end

        ST_LOAD: begin
          value <= value_ok(bus.rd_data, fmin, fmax) ? bus.rd_data : fmin;
          if (!escribe) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (crono && campo != '0) begin
            campo <= '0;
          end else begin
            state <= ST_EDIT;
            busy  <= 1'b0;
          end
        end

        ST_EDIT: begin
          if (!escribe) begin
            state <= ST_IDLE;
          end else if (crono) begin
            campo <= '0;
            state <= ST_LOAD;
            busy  <= 1'b1;
          end else if (one_edge) begin
            busy <= 1'b1;
            if (btn_edge[3]) begin
              campo <= (campo == LAST_FIELD) ? 4'd0 : campo + 4'd1;
              state <= ST_LOAD;
            end else if (btn_edge[2]) begin
              campo <= (campo == 4'd0) ? LAST_FIELD : campo - 4'd1;
              state <= ST_LOAD;
            end else begin
              value      <= step_val;
              bus.wr_req <= 1'b1;
              state      <= ST_WRITE;
            end
          end
        end

        ST_WRITE: begin
          if (crono) crono_pend <= 1'b1;
          if (bus.wr_ack) begin
            bus.wr_req <= 1'b0;
            crono_pend <= 1'b0;
            if (!escribe) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (crono || crono_pend) begin
              campo <= '0;
              state <= ST_LOAD;
            end else begin
              state <= ST_EDIT;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
